// File: rtl/tx_scheduler_pkg.sv
// Shared encodings and helpers for the tx_scheduler block.
package tx_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SEND     = 3'd2,
    WAIT_END = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  localparam int TIMEOUT_DEF = 2047;

  // One-hot (up to 8 requesters) to binary index.
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    oh2idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) oh2idx = 3'(i);
  endfunction

endpackage

// File: rtl/tx_scheduler_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr wins.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan from farthest to nearest so the requester closest to ptr is written last.
  always_comb begin
    pick = '0;
    sum  = '0;
    idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// Round-robin transmit scheduler driving a serial transmitter handshake.
// Optional WAIT_END watchdog is compiled in with `define TX_WATCHDOG_EN.
module tx_scheduler
  import tx_scheduler_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic              dsr,
  input  logic              tx_end,
  output logic [NREQ-1:0]   gnt,
  output logic              load,
  output logic              send,
  output logic [7:0]        tx_data,
  output logic [NREQ-1:0]   done,
  output logic              error,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gidx;
  logic [NREQ-1:0] pick;
  logic [PW-1:0]   pick_idx;
  logic            wd_expire;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick)
  );

  assign pick_idx = PW'(oh2idx(8'(pick)));

`ifdef TX_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;

  // Expires on the TIMEOUT-th consecutive WAIT_END cycle without tx_end.
  assign wd_expire = (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                       wd_cnt <= '0;
    else if (state == WAIT_END && !tx_end && !wd_expire) wd_cnt <= wd_cnt + 1'b1;
    else                                                wd_cnt <= '0;
  end
`else
  // No watchdog: constant-false expiry; TIMEOUT only matters in the watchdog build.
  assign wd_expire = (TIMEOUT < 0);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      gnt     <= '0;
      load    <= 1'b0;
      send    <= 1'b0;
      tx_data <= '0;
      done    <= '0;
      error   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      load <= 1'b0;
      send <= 1'b0;
      done <= '0;
      if (tx_end && state != WAIT_END) error <= 1'b1;
      case (state)
        // Byte is captured on the grant edge so it is stable while load is high.
        IDLE: if (|req) begin
          gnt     <= pick;
          gidx    <= pick_idx;
          tx_data <= req_data[{pick_idx, 3'b000} +: 8];
          load    <= 1'b1;
          busy    <= 1'b1;
          state   <= LOAD;
        end
        // dsr is registered here so the send pulse coincides with SEND.
        LOAD: begin
          send  <= dsr;
          state <= SEND;
        end
        SEND: if (send) state <= WAIT_END;
              else begin
                error <= 1'b1;
                state <= RELEASE;
              end
        WAIT_END: if (tx_end) begin
          done  <= gnt;
          error <= 1'b0;
          state <= RELEASE;
        end else if (wd_expire) begin
          error <= 1'b1;
          state <= RELEASE;
        end
        RELEASE: begin
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed self-checking bench for tx_scheduler (NREQ=4, TIMEOUT=16).
module tb_tx_scheduler;

  localparam int NREQ = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic              dsr = 1'b0;
  logic              tx_end = 1'b0;
  logic [NREQ-1:0]   gnt;
  logic              load;
  logic              send;
  logic [7:0]        tx_data;
  logic [NREQ-1:0]   done;
  logic              error;
  logic              busy;

  int errors = 0;
  int checks = 0;

  tx_scheduler #(.NREQ(NREQ), .TIMEOUT(16)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .req_data (req_data),
    .dsr      (dsr),
    .tx_end   (tx_end),
    .gnt      (gnt),
    .load     (load),
    .send     (send),
    .tx_data  (tx_data),
    .done     (done),
    .error    (error),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; dsr = 1'b0; tx_end = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc(2);
    checks++;
    if ({gnt, load, send, tx_data, done, error, busy} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b load=%b send=%b tx_data=%h done=%b error=%b busy=%b required all 0",
               gnt, load, send, tx_data, done, error, busy);
    end
    reset_n = 1'b1;
    cyc(1);
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: busy=%b gnt=%b required busy=0 gnt=0000", busy, gnt);
    end
  endtask

  task automatic test_basic();
    do_reset();
    req_data = 32'h0000_00A5; dsr = 1'b1; req = 4'b0001;
    cyc(1);
    req = 4'b0000;  // dropping req after grant must not abort the transfer
    checks++;
    if (load !== 1'b1 || send !== 1'b0 || gnt !== 4'b0001 || tx_data !== 8'hA5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_load: load=%b send=%b gnt=%b tx_data=%h busy=%b required 1 0 0001 a5 1",
               load, send, gnt, tx_data, busy);
    end
    cyc(1);
    checks++;
    if (load !== 1'b0 || send !== 1'b1) begin
      errors++;
      $display("FAIL basic_send: load=%b send=%b required load=0 send=1", load, send);
    end
    cyc(1);
    checks++;
    if (send !== 1'b0 || gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_wait: send=%b gnt=%b busy=%b required 0 0001 1", send, gnt, busy);
    end
    cyc(18);
    checks++;
    if (done !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_no_early_done: done=%b busy=%b required 0000 1", done, busy);
    end
    cyc(1);
    tx_end = 1'b1;
    cyc(1);
    tx_end = 1'b0;
    checks++;
    if (done !== 4'b0001 || error !== 1'b0 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL basic_done: done=%b error=%b gnt=%b required 0001 0 0001", done, error, gnt);
    end
    cyc(1);
    checks++;
    if (done !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: done=%b gnt=%b busy=%b required 0000 0000 0", done, gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    int t;
    do_reset();
    req_data = 32'h4433_2211; dsr = 1'b1; req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_d = 8'((k % 4 + 1) * 17);
      t = 0;
      while (load !== 1'b1 && t < 10) begin
        cyc(1);
        t++;
      end
      checks++;
      if (load !== 1'b1 || gnt !== exp_g || tx_data !== exp_d) begin
        errors++;
        $display("FAIL rr_grant[%0d]: load=%b gnt=%b tx_data=%h required 1 %b %h",
                 k, load, gnt, tx_data, exp_g, exp_d);
      end
      cyc(2);
      tx_end = 1'b1;
      cyc(1);
      tx_end = 1'b0;
      checks++;
      if (done !== exp_g || error !== 1'b0) begin
        errors++;
        $display("FAIL rr_done[%0d]: done=%b error=%b required %b 0", k, done, error, exp_g);
      end
    end
    req = 4'b0000;
    cyc(3);
  endtask

  task automatic test_dsr_low();
    do_reset();
    req_data = 32'h0000_775A; dsr = 1'b0; req = 4'b0001;
    cyc(1);
    req = 4'b0000;
    checks++;
    if (load !== 1'b1 || tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL dsr_load: load=%b tx_data=%h required 1 5a", load, tx_data);
    end
    cyc(1);
    checks++;
    if (send !== 1'b0) begin
      errors++;
      $display("FAIL dsr_no_send: send=%b required 0", send);
    end
    cyc(1);
    checks++;
    if (error !== 1'b1 || done !== 4'b0000 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL dsr_error: error=%b done=%b gnt=%b required 1 0000 0001", error, done, gnt);
    end
    cyc(1);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || error !== 1'b1) begin
      errors++;
      $display("FAIL dsr_release: gnt=%b busy=%b error=%b required 0000 0 1", gnt, busy, error);
    end
    dsr = 1'b1; req = 4'b0010;
    cyc(1);
    req = 4'b0000;
    checks++;
    if (gnt !== 4'b0010 || tx_data !== 8'h77) begin
      errors++;
      $display("FAIL dsr_retry_grant: gnt=%b tx_data=%h required 0010 77", gnt, tx_data);
    end
    cyc(2);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL dsr_sticky: error=%b required 1", error);
    end
    tx_end = 1'b1;
    cyc(1);
    tx_end = 1'b0;
    checks++;
    if (done !== 4'b0010 || error !== 1'b0) begin
      errors++;
      $display("FAIL dsr_clear: done=%b error=%b required 0010 0", done, error);
    end
    cyc(2);
  endtask

  task automatic test_tx_end_idle();
    do_reset();
    tx_end = 1'b1;
    cyc(1);
    tx_end = 1'b0;
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || gnt !== 4'b0000 || load !== 1'b0) begin
      errors++;
      $display("FAIL idle_tx_end: error=%b busy=%b gnt=%b load=%b required 1 0 0000 0",
               error, busy, gnt, load);
    end
    cyc(2);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_tx_end_sticky: error=%b busy=%b required 1 0", error, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data = 32'hDD_CC_BB_AA; dsr = 1'b1; req = 4'b0100;
    cyc(1);
    req = 4'b0000;
    cyc(2);
    tx_end = 1'b1;
    cyc(1);
    tx_end = 1'b0;
    cyc(1);
    req = 4'b1000;
    cyc(1);
    req = 4'b0000;
    checks++;
    if (gnt !== 4'b1000 || tx_data !== 8'hDD) begin
      errors++;
      $display("FAIL mid_pre_grant: gnt=%b tx_data=%h required 1000 dd", gnt, tx_data);
    end
    cyc(2);
    checks++;
    if (busy !== 1'b1 || gnt !== 4'b1000) begin
      errors++;
      $display("FAIL mid_wait: busy=%b gnt=%b required 1 1000", busy, gnt);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({gnt, load, send, tx_data, done, error, busy} !== 19'd0) begin
      errors++;
      $display("FAIL mid_async_reset: gnt=%b load=%b send=%b tx_data=%h done=%b error=%b busy=%b required all 0",
               gnt, load, send, tx_data, done, error, busy);
    end
    tx_end = 1'b1;
    cyc(1);
    tx_end = 1'b0;
    checks++;
    if (done !== 4'b0000 || error !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done: done=%b error=%b required 0000 0", done, error);
    end
    reset_n = 1'b1;
    req = 4'b1111;
    cyc(1);
    req = 4'b0000;
    checks++;
    if (gnt !== 4'b0001 || tx_data !== 8'hAA) begin
      errors++;
      $display("FAIL mid_ptr_zero: gnt=%b tx_data=%h required 0001 aa", gnt, tx_data);
    end
    do_reset();
  endtask

`ifdef TX_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    req_data = 32'h0000_0033; dsr = 1'b1; req = 4'b0001;
    cyc(1);
    req = 4'b0000;
    cyc(2);
    cyc(15);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wd_before: error=%b busy=%b required 0 1", error, busy);
    end
    cyc(1);
    checks++;
    if (error !== 1'b1 || done !== 4'b0000) begin
      errors++;
      $display("FAIL wd_expire: error=%b done=%b required 1 0000", error, done);
    end
    cyc(1);
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000 || error !== 1'b1) begin
      errors++;
      $display("FAIL wd_idle: busy=%b gnt=%b error=%b required 0 0000 1", busy, gnt, error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_dsr_low();
    test_tx_end_idle();
    test_reset_mid();
`ifdef TX_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 2047, SHALL set the maximum cycles in WAIT_END when the watchdog is compiled in.
REQ-003 clock  input  1  SHALL be the single clock; all state changes on posedge clock.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  NREQ  SHALL carry level requests; bit i high means requester i has a byte.
REQ-006 req_data  input  8*NREQ  SHALL carry packed bytes; byte i occupies bits [8i+7:8i].
REQ-007 dsr  input  1  SHALL be the data-set-ready from the line partner.
REQ-008 tx_end  input  1  SHALL be the one-cycle end-of-frame pulse from the serial transmitter.
REQ-009 gnt  output  NREQ  SHALL be the one-hot grant, held from LOAD through RELEASE.
REQ-010 load  output  1  SHALL be a one-cycle pulse telling the transmitter to capture tx_data.
REQ-011 send  output  1  SHALL be a one-cycle pulse starting transmission.
REQ-012 tx_data  output  8  SHALL be the granted byte, registered in LOAD.
REQ-013 done  output  NREQ  SHALL be a one-cycle pulse to the served requester on successful completion.
REQ-014 error  output  1  SHALL be a sticky error flag.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SEND, WAIT_END and RELEASE.
REQ-017 IDLE: if any req is high, the FSM SHALL pick the requester by round-robin starting at ptr, assert gnt and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-018 LOAD: the FSM SHALL latch tx_data from the granted byte, pulse load and go to SEND.
REQ-019 SEND: if dsr=1, the FSM SHALL pulse send and go to WAIT_END; if dsr=0, it SHALL set error, not pulse send, and go to RELEASE with no done.
REQ-020 WAIT_END: on tx_end=1, the FSM SHALL pulse done[granted] in the same cycle as the move to RELEASE.
REQ-021 RELEASE: the FSM SHALL clear gnt, set ptr to granted+1 modulo NREQ and go to IDLE; minimum IDLE-to-IDLE is 4 cycles.
REQ-022 Latency: load SHALL be asserted exactly 1 cycle after the req sample in IDLE, and send exactly 2 cycles after it.
REQ-023 ptr wrap: granted=NREQ-1 SHALL give ptr=0.
REQ-024 Deassertion of req while granted SHALL be ignored; the transfer SHALL complete.
REQ-025 A tx_end outside WAIT_END SHALL be ignored and SHALL set error.
REQ-026 error SHALL clear only on reset or on the next successful done pulse.

Reset
REQ-027 While reset_n=0, outputs SHALL be: gnt=0, load=0, send=0, tx_data=0, done=0, error=0, busy=0.
REQ-028 While reset_n=0, internal state SHALL be: FSM=IDLE, ptr=0, watchdog counter=0.
REQ-029 Reset asserted mid-transfer SHALL abort immediately with no done pulse.

Configuration
REQ-030 With TX_WATCHDOG_EN defined, a counter SHALL run in WAIT_END; reaching TIMEOUT without tx_end SHALL set error and go to RELEASE with no done.
REQ-031 Without TX_WATCHDOG_EN, WAIT_END SHALL wait for tx_end indefinitely and no counter SHALL be synthesized.

Structure
REQ-032 A shared package SHALL hold the state encodings (IDLE=3'd0, LOAD=3'd1, SEND=3'd2, WAIT_END=3'd3, RELEASE=3'd4) and the TIMEOUT default.
REQ-033 The round-robin selector SHALL be the sub-module rr_pick: combinational, with inputs req and ptr and a one-hot output.

Verification
REQ-034 req=4'b0001, byte0=8'hA5, dsr=1, tx_end 20 cycles after send -> load at +1, send at +2, tx_data=A5, done=4'b0001, error=0.
REQ-035 req=4'b1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3 with ptr wrap after 3.
REQ-036 dsr=0 at SEND -> no send pulse, error=1, no done, gnt released; next good transfer clears error.
REQ-037 TX_WATCHDOG_EN, TIMEOUT=16, no tx_end -> error=1 after 16 WAIT_END cycles, FSM returns to IDLE.
REQ-038 reset_n pulled low in WAIT_END -> all outputs 0 asynchronously, no done, ptr=0 afterwards.
REQ-039 tx_end pulse while IDLE -> error=1, no state change.
